mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//   Shares one synchronous single-port word RAM between the SCPU instruction port and data port.
//   Replaces the fixed split Inst_ROM/Data_RAM hookup with a unified, parametrised memory path.
//   Adds per-port stall handshakes, configurable RAM latency and wait states, and byte-enable writes.
//   Selects fixed data-priority or round-robin arbitration.
//   Sits between SCPU and the unified RAM inside the mips top level.
// PARAMETERS
//   ADDR_W      10  word-address width to RAM; byte address bits [ADDR_W+1:2] used, upper bits ignored
//   RAM_LAT     1   RAM read latency in cycles (>=1): ram_dout valid RAM_LAT cycles after ram_en
//   WAIT_STATES 0   extra cycles inserted per access (>=0)
//   ARB_MODE    0   0 = data port always wins; 1 = round-robin on simultaneous requests
// PORTS
//   clk        in   1       system clock, all state on rising edge
//   rst        in   1       asynchronous reset, active-high
//   inst_ren   in   1       instruction fetch request, held by CPU until inst_stall low
//   inst_addr  in   32      fetch byte address
//   inst_data  out  32      fetched word, registered
//   inst_stall out  1       1 = fetch not complete this cycle
//   mem_ren    in   1       data read request
//   mem_wen    in   1       data write request (wins if mem_ren also high)
//   mem_ben    in   4       write byte enables, bit i -> bits [8i+7:8i]
//   mem_addr   in   32      data byte address
//   mem_dout   in   32      write data from CPU
//   mem_din    out  32      read data to CPU, registered
//   mem_stall  out  1       1 = data access not complete this cycle
//   ram_en     out  1       RAM access strobe, one cycle per access
//   ram_we     out  4       RAM byte write enables (0 for reads)
//   ram_addr   out  ADDR_W  RAM word address
//   ram_din    out  32      RAM write data
//   ram_dout   in   32      RAM read data
//   busy       out  1       1 when state != IDLE
// BEHAVIOUR
//   Reset values:
//     - state = IDLE; ram_en = 0; ram_we = 0; ram_addr = 0; ram_din = 0
//     - inst_data = 0; mem_din = 0; last_grant = INST.
//   Requests:
//     - A data request is mem_ren | mem_wen; an instruction request is inst_ren.
//     - Stalls are combinational: inst_stall = inst_ren & ~(state==DONE & grant==INST).
//     - mem_stall is the same term for the data port.
//   FSM states:
//     - IDLE: if any request is present, latch grant, address, ben and wdata; go to ACCESS.
//     - ACCESS (1 cycle): ram_en = 1; ram_we = mem_ben when the granted access is a write, else 0.
//       Go to WAIT if RAM_LAT + WAIT_STATES > 1, else go to DONE.
//     - WAIT: a counter runs RAM_LAT + WAIT_STATES - 1 cycles, then goes to DONE.
//       ram_en and ram_we are 0 throughout WAIT.
//     - DONE (1 cycle): for a read, ram_dout is captured into inst_data or mem_din at the clock edge ending DONE.
//       The granted stall is low during DONE.
//       Next state is ACCESS if another request is pending (grant re-decided), else IDLE.
//   Latency: request to stall-low cycle = RAM_LAT + WAIT_STATES + 1 cycles.
//     - Minimum is 2 cycles (RAM_LAT=1, WS=0).
//     - Back-to-back throughput is one access per RAM_LAT + WAIT_STATES + 1 cycles.
//   Arbitration on simultaneous requests:
//     - ARB_MODE=0: data port is always granted.
//     - ARB_MODE=1: the port not granted last time wins.
//     - A lone request is granted immediately in both modes.
//   The data-out register (inst_data or mem_din) holds its value until the next read completes on that port.
//   Writes never change mem_din.
//   Request dropped mid-access: the access still completes and a write is still committed.
//     Read data is still captured; no stall is reported.
//   Address and data latching:
//     - Request inputs are sampled only when granting.
//     - Changes to address or data while stalled are ignored.
//   Address bits above ADDR_W+1 and bits [1:0] are ignored; there is no alignment fault.
//   Reset mid-access:
//     - Returns to IDLE immediately and drops ram_en and ram_we.
//     - An in-flight write may or may not be committed in RAM; it is not retried.
// TESTING
//   - Reset, no requests: all outputs 0, busy=0, stalls 0.
//   - RAM_LAT=1, WS=0; inst_ren @0x04, RAM[1]=0x2010_0005: inst_stall=1 for 2 cycles, low in cycle 3.
//     inst_data=0x2010_0005 afterwards.
//   - Write mem_addr=0x40, ben=4'b0011, dout=0xAABBCCDD over RAM[16]=0x11223344, then read 0x40.
//     Required: mem_din=0x1122CCDD.
//   - ARB_MODE=1, inst and data requests held together for 4 accesses: grants alternate D,I,D,I.
//     With ARB_MODE=0 the grant stays D while mem_ren is held.
//   - RAM_LAT=2, WS=3: read stall lasts 6 cycles; ram_en is high exactly 1 cycle per access.
//   - Assert rst during WAIT of a read: busy=0, ram_en=0, mem_din=0 next cycle.
//     A re-issued read completes normally.

Source files
------------

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - CPU-port and RAM-port signal bundle for mips_mem_arbiter
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              inst_ren;
    logic [31:0]       inst_addr;
    logic [31:0]       inst_data;
    logic              inst_stall;
    logic              mem_ren;
    logic              mem_wen;
    logic [3:0]        mem_ben;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_dout;
    logic [31:0]       mem_din;
    logic              mem_stall;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic              busy;

    modport slave (
        input  inst_ren, inst_addr, mem_ren, mem_wen, mem_ben, mem_addr, mem_dout, ram_dout,
        output inst_data, inst_stall, mem_din, mem_stall, ram_en, ram_we, ram_addr, ram_din, busy
    );

    modport master (
        output inst_ren, inst_addr, mem_ren, mem_wen, mem_ben, mem_addr, mem_dout, ram_dout,
        input  inst_data, inst_stall, mem_din, mem_stall, ram_en, ram_we, ram_addr, ram_din, busy
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - shares one single-port word RAM between the SCPU fetch and data ports
module mips_mem_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int RAM_LAT     = 1,
    parameter int WAIT_STATES = 0,
    parameter int ARB_MODE    = 0
) (
    input  logic               clk,
    input  logic               rst,
    mips_mem_arbiter_if.slave  bus
);
    localparam int LAT_TOTAL = RAM_LAT + WAIT_STATES;
    localparam int CNT_W     = $clog2(LAT_TOTAL + 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(LAT_TOTAL - 2);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
    typedef enum logic {G_INST, G_DATA} grant_t;

    state_t            state_q;
    grant_t            grant_q, last_grant_q, grant_d;
    logic              write_q, write_d;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              ram_en_q;
    logic [3:0]        ram_we_q, we_d;
    logic [ADDR_W-1:0] ram_addr_q, addr_d;
    logic [31:0]       ram_din_q, inst_data_q, mem_din_q;
    logic              data_req, any_req;
    logic              unused_addr_bits;

    assign unused_addr_bits = &{bus.inst_addr[31:ADDR_W+2], bus.inst_addr[1:0],
                                bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

    // Grant decision; only consumed in IDLE and DONE, where requests are sampled.
    always_comb begin
        data_req = bus.mem_ren | bus.mem_wen;
        any_req  = data_req | bus.inst_ren;
        grant_d  = G_INST;
        if (data_req && (!bus.inst_ren || ARB_MODE == 0 || last_grant_q == G_INST)) begin
            grant_d = G_DATA;
        end
        write_d = (grant_d == G_DATA) && bus.mem_wen;
        addr_d  = (grant_d == G_DATA) ? bus.mem_addr[ADDR_W+1:2] : bus.inst_addr[ADDR_W+1:2];
        we_d    = write_d ? bus.mem_ben : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= G_INST;
            last_grant_q <= G_INST;
            write_q      <= 1'b0;
            wait_cnt_q   <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'b0000;
            ram_addr_q   <= '0;
            ram_din_q    <= 32'h0;
            inst_data_q  <= 32'h0;
            mem_din_q    <= 32'h0;
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= 4'b0000;
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE && !write_q) begin
                        if (grant_q == G_DATA) mem_din_q   <= bus.ram_dout;
                        else                   inst_data_q <= bus.ram_dout;
                    end
                    if (any_req) begin
                        state_q      <= ACCESS;
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        write_q      <= write_d;
                        ram_en_q     <= 1'b1;
                        ram_we_q     <= we_d;
                        ram_addr_q   <= addr_d;
                        if (write_d) ram_din_q <= bus.mem_dout;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    if (LAT_TOTAL > 1) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= WAIT_INIT;
                    end else begin
                        state_q <= DONE;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == '0) state_q <= DONE;
                    else                  wait_cnt_q <= wait_cnt_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.inst_stall = bus.inst_ren & ~(state_q == DONE && grant_q == G_INST);
    assign bus.mem_stall  = data_req     & ~(state_q == DONE && grant_q == G_DATA);
    assign bus.inst_data  = inst_data_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb/tb_mips_mem_arbiter.sv - self-checking bench for mips_mem_arbiter over three configurations
module tb_mips_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Config 0: LAT1/WS0/fixed, config 1: LAT1/WS0/round-robin, config 2: LAT2/WS3/round-robin
    logic        inst_ren_s [3];
    logic [31:0] inst_addr_s [3];
    logic [31:0] inst_data_s [3];
    logic        inst_stall_s [3];
    logic        mem_ren_s [3];
    logic        mem_wen_s [3];
    logic [3:0]  mem_ben_s [3];
    logic [31:0] mem_addr_s [3];
    logic [31:0] mem_dout_s [3];
    logic [31:0] mem_din_s [3];
    logic        mem_stall_s [3];
    logic        ram_en_s [3];
    logic [3:0]  ram_we_s [3];
    logic [9:0]  ram_addr_s [3];
    logic [31:0] ram_din_s [3];
    logic        busy_s [3];

    int nvec = 0;
    int nerr = 0;

    function automatic logic [31:0] init_val(input int g, input int idx);
        case ({g[1:0], idx[9:0]})
            {2'd0, 10'd1}:  return 32'h2010_0005;
            {2'd0, 10'd16}: return 32'h1122_3344;
            {2'd1, 10'd4}:  return 32'h0000_1111;
            {2'd1, 10'd32}: return 32'h0000_2222;
            {2'd2, 10'd5}:  return 32'hCAFE_0001;
            {2'd2, 10'd6}:  return 32'hBEEF_0002;
            default:        return 32'h0;
        endcase
    endfunction

    for (genvar G = 0; G < 3; G++) begin : cfg
        localparam int L = (G == 2) ? 2 : 1;
        localparam int W = (G == 2) ? 3 : 0;
        localparam int A = (G == 0) ? 0 : 1;
        logic [31:0] bram [0:1023];
        logic [31:0] rdout;

        mips_mem_arbiter_if #(.ADDR_W(10)) bus ();

        assign bus.inst_ren  = inst_ren_s[G];
        assign bus.inst_addr = inst_addr_s[G];
        assign bus.mem_ren   = mem_ren_s[G];
        assign bus.mem_wen   = mem_wen_s[G];
        assign bus.mem_ben   = mem_ben_s[G];
        assign bus.mem_addr  = mem_addr_s[G];
        assign bus.mem_dout  = mem_dout_s[G];
        assign bus.ram_dout  = rdout;
        assign inst_data_s[G]  = bus.inst_data;
        assign inst_stall_s[G] = bus.inst_stall;
        assign mem_din_s[G]    = bus.mem_din;
        assign mem_stall_s[G]  = bus.mem_stall;
        assign ram_en_s[G]     = bus.ram_en;
        assign ram_we_s[G]     = bus.ram_we;
        assign ram_addr_s[G]   = bus.ram_addr;
        assign ram_din_s[G]    = bus.ram_din;
        assign busy_s[G]       = bus.busy;

        mips_mem_arbiter #(.ADDR_W(10), .RAM_LAT(L), .WAIT_STATES(W), .ARB_MODE(A)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        initial begin
            rdout <= 32'h0;
            for (int i = 0; i < 1024; i++) bram[i] <= init_val(G, i);
        end

        always @(posedge clk) begin
            if (bus.ram_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.ram_we[b]) bram[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
                end
            end
        end

        if (L == 1) begin : lat1
            always @(posedge clk) if (bus.ram_en) rdout <= bram[bus.ram_addr];
        end else begin : lat2
            logic        pv;
            logic [31:0] pd;
            initial pv <= 1'b0;
            always @(posedge clk) begin
                pv <= bus.ram_en;
                pd <= bram[bus.ram_addr];
                if (pv) rdout <= pd;
            end
        end
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[cfg%0d]: got %h, want %h", nm, g, act, exp);
        end
    endtask

    // Transaction-level model: each access occupies cycles 1..T after its grant (T = LAT+WS+1).
    int          ph [3];
    logic        gr [3];
    logic        wr [3];
    logic        lastg [3];
    logic [9:0]  maddr [3];
    logic [3:0]  mben [3];
    logic [31:0] mwd [3];
    logic [31:0] idat_m [3];
    logic [31:0] ddat_m [3];
    logic [31:0] mmem [3][0:1023];
    logic        dlog [3][16];
    int          dcnt [3];

    initial begin
        for (int g = 0; g < 3; g++) begin
            dcnt[g] = 0;
            for (int i = 0; i < 1024; i++) mmem[g][i] = init_val(g, i);
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            automatic int   t    = (g == 2) ? 6 : 2;
            automatic int   arb  = (g == 0) ? 0 : 1;
            automatic logic ireq = inst_ren_s[g];
            automatic logic dreq = mem_ren_s[g] | mem_wen_s[g];
            automatic logic pick;
            if (rst) begin
                ph[g] = 0; gr[g] = 0; wr[g] = 0; lastg[g] = 0;
                idat_m[g] = 32'h0; ddat_m[g] = 32'h0;
            end
            chk("busy", g, busy_s[g], ph[g] != 0);
            chk("ram_en", g, ram_en_s[g], ph[g] == 1);
            chk("ram_we", g, ram_we_s[g], (ph[g] == 1 && wr[g]) ? mben[g] : 4'b0000);
            chk("inst_stall", g, inst_stall_s[g], ireq && !(ph[g] == t && gr[g] == 0));
            chk("mem_stall", g, mem_stall_s[g], dreq && !(ph[g] == t && gr[g] == 1));
            chk("inst_data", g, inst_data_s[g], idat_m[g]);
            chk("mem_din", g, mem_din_s[g], ddat_m[g]);
            if (ph[g] == 1) chk("ram_addr", g, ram_addr_s[g], maddr[g]);
            if (ph[g] == 1 && wr[g]) chk("ram_din", g, ram_din_s[g], mwd[g]);
            if (ram_en_s[g] && dcnt[g] < 16) begin
                dlog[g][dcnt[g]] = (ram_addr_s[g] == 10'd32);
                dcnt[g]++;
            end
            if (!rst) begin
                if (ph[g] == t && !wr[g]) begin
                    if (gr[g]) ddat_m[g] = mmem[g][maddr[g]];
                    else       idat_m[g] = mmem[g][maddr[g]];
                end
                if (ph[g] == 0 || ph[g] == t) begin
                    if (ireq || dreq) begin
                        pick     = dreq && (!ireq || arb == 0 || lastg[g] == 0);
                        gr[g]    = pick;
                        lastg[g] = pick;
                        wr[g]    = pick && mem_wen_s[g];
                        maddr[g] = pick ? mem_addr_s[g][11:2] : inst_addr_s[g][11:2];
                        mben[g]  = mem_ben_s[g];
                        mwd[g]   = mem_dout_s[g];
                        if (wr[g]) begin
                            for (int b = 0; b < 4; b++)
                                if (mben[g][b]) mmem[g][maddr[g]][8*b +: 8] = mwd[g][8*b +: 8];
                        end
                        ph[g] = 1;
                    end else begin
                        ph[g] = 0;
                    end
                end else begin
                    ph[g]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_s[g]) break;
        end
        chk("reach_idle", g, busy_s[g], 0);
        step();
    endtask

    // kind: 0 = fetch, 1 = data read, 2 = data write. Request is held until its stall drops.
    task automatic access(input int g, input int kind, input logic [31:0] addr,
                          input logic [3:0] ben, input logic [31:0] wd,
                          output int stall_cyc, output int en_cnt);
        logic st;
        stall_cyc = 0;
        en_cnt    = 0;
        st        = 1'b1;
        if (kind == 0) begin
            inst_ren_s[g]  = 1'b1;
            inst_addr_s[g] = addr;
        end else begin
            mem_ren_s[g]  = (kind == 1);
            mem_wen_s[g]  = (kind == 2);
            mem_addr_s[g] = addr;
            mem_ben_s[g]  = ben;
            mem_dout_s[g] = wd;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ram_en_s[g]) en_cnt++;
            st = (kind == 0) ? inst_stall_s[g] : mem_stall_s[g];
            if (!st) break;
            stall_cyc++;
        end
        chk("stall_release", g, st, 0);
        step();
        inst_ren_s[g] = 1'b0;
        mem_ren_s[g]  = 1'b0;
        mem_wen_s[g]  = 1'b0;
        wait_idle(g);
    endtask

    initial begin
        int sc, ec;
        for (int g = 0; g < 3; g++) begin
            inst_ren_s[g] = 1'b0; inst_addr_s[g] = 32'h0;
            mem_ren_s[g]  = 1'b0; mem_wen_s[g]   = 1'b0;
            mem_ben_s[g]  = 4'h0; mem_addr_s[g]  = 32'h0; mem_dout_s[g] = 32'h0;
        end
        step();
        step();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", 0, busy_s[0], 0);
        chk("rst_ram_en", 0, ram_en_s[0], 0);
        chk("rst_ram_we", 0, ram_we_s[0], 0);
        chk("rst_ram_addr", 0, ram_addr_s[0], 0);
        chk("rst_ram_din", 0, ram_din_s[0], 0);
        chk("rst_inst_data", 0, inst_data_s[0], 0);
        chk("rst_mem_din", 0, mem_din_s[0], 0);
        chk("rst_stalls", 0, {inst_stall_s[0], mem_stall_s[0]}, 0);
        step();

        access(0, 0, 32'h0000_0004, 4'h0, 32'h0, sc, ec);
        chk("fetch_stall_cycles", 0, sc, 2);
        chk("fetch_data", 0, inst_data_s[0], 32'h2010_0005);

        access(0, 2, 32'h0000_0040, 4'b0011, 32'hAABB_CCDD, sc, ec);
        chk("write_stall_cycles", 0, sc, 2);
        chk("write_keeps_mem_din", 0, mem_din_s[0], 32'h0);
        access(0, 1, 32'h0000_0040, 4'h0, 32'h0, sc, ec);
        chk("byte_merge", 0, mem_din_s[0], 32'h1122_CCDD);
        access(0, 1, 32'hFFFF_F007, 4'h0, 32'h0, sc, ec);
        chk("addr_bits_ignored", 0, mem_din_s[0], 32'h2010_0005);

        for (int g = 0; g < 2; g++) begin
            dcnt[g]        = 0;
            inst_ren_s[g]  = 1'b1; inst_addr_s[g] = 32'h10;
            mem_ren_s[g]   = 1'b1; mem_addr_s[g]  = 32'h80;
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dcnt[1] >= 4) break;
        end
        chk("arb_progress", 1, dcnt[1] >= 4, 1);
        step();
        for (int g = 0; g < 2; g++) begin
            inst_ren_s[g] = 1'b0;
            mem_ren_s[g]  = 1'b0;
        end
        wait_idle(0);
        wait_idle(1);
        chk("rr_grants", 1, {dlog[1][0], dlog[1][1], dlog[1][2], dlog[1][3]}, 4'b1010);
        chk("fixed_grants", 0, {dlog[0][0], dlog[0][1], dlog[0][2], dlog[0][3]}, 4'b1111);
        chk("rr_inst_data", 1, inst_data_s[1], 32'h0000_1111);
        chk("rr_mem_din", 1, mem_din_s[1], 32'h0000_2222);
        chk("fixed_mem_din", 0, mem_din_s[0], 32'h0);

        access(2, 1, 32'h0000_0014, 4'h0, 32'h0, sc, ec);
        chk("slow_stall_cycles", 2, sc, 6);
        chk("slow_ram_en_count", 2, ec, 1);
        chk("slow_read_data", 2, mem_din_s[2], 32'hCAFE_0001);

        mem_ren_s[2]  = 1'b1;
        mem_addr_s[2] = 32'h18;
        step();
        step();
        rst = 1'b1;
        mem_ren_s[2] = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 2, busy_s[2], 0);
        chk("midrst_ram_en", 2, ram_en_s[2], 0);
        chk("midrst_mem_din", 2, mem_din_s[2], 0);
        step();
        rst = 1'b0;
        step();
        access(2, 1, 32'h0000_0018, 4'h0, 32'h0, sc, ec);
        chk("reissue_stall_cycles", 2, sc, 6);
        chk("reissue_data", 2, mem_din_s[2], 32'hBEEF_0002);

        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
